// File: rtl/pipe_stage_pkg.sv
// Shared types and constants for the generic pipeline-stage register.
package pipe_stage_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } pstage_state_t;

  localparam int DEPTH_LATCH = 1;
  localparam int DEPTH_SKID  = 2;

  function automatic logic [1:0] state_occupancy(input pstage_state_t s);
    logic [1:0] occ;
    case (s)
      EMPTY:   occ = 2'd0;
      HALF:    occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register: data + control payload through a valid/ready
// handshake, optional 2-entry skid buffer, flush-to-bubble and a bubble counter.
module pipe_stage_reg
  import pipe_stage_pkg::*;
#(
  parameter int                DATA_W      = 64,
  parameter int                CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
  parameter int                DEPTH       = 1,
  parameter int                CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [1:0]        dbg_state
);

  if (DEPTH != DEPTH_LATCH && DEPTH != DEPTH_SKID) begin : g_bad_depth
    $fatal(1, "pipe_stage_reg: DEPTH must be 1 or 2");
  end

  pstage_state_t     state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              in_ready_q, in_ready_d;
  logic              main_valid;
  logic              in_fire;
  logic              out_fire;
  logic              bubble_inc;

  // Handshake: a beat moves on a side only in a cycle where both valid and
  // ready are high at the rising edge; flush kills the output beat and any
  // concurrent input beat, so neither side transfers while it is asserted.
  assign main_valid = (state_q != EMPTY);
  assign out_valid  = main_valid & ~flush;
  assign out_fire   = out_valid & out_ready;
  assign in_fire    = in_valid & in_ready & ~flush;
  assign out_data   = out_valid ? main_data_q : '0;
  assign out_ctrl   = out_valid ? main_ctrl_q : BUBBLE_CTRL;

  // The skid variant has no combinational path from out_ready to in_ready.
  assign in_ready = (DEPTH == DEPTH_SKID) ? in_ready_q
                                          : ((state_q == EMPTY) | out_ready);

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d     = EMPTY;
      main_data_d = '0;
      main_ctrl_d = BUBBLE_CTRL;
      skid_data_d = '0;
      skid_ctrl_d = BUBBLE_CTRL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d     = HALF;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        HALF: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (out_fire) begin
            state_d = EMPTY;
          end else if (in_fire && (DEPTH == DEPTH_SKID)) begin
            state_d     = FULL;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d     = HALF;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= BUBBLE_CTRL;
      skid_data_q <= '0;
      skid_ctrl_q <= BUBBLE_CTRL;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign occupancy  = state_occupancy(state_q);
  assign dbg_state  = state_q;
  assign bubble_inc = ~out_valid;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_bubble_cnt (
    .clk(CLK),
    .rst(RST),
    .inc(bubble_inc),
    .clr(cnt_clr),
    .cnt(bubble_cnt)
  );

endmodule
